mdio_arbiter: RTL

Shares the single MDIO frame engine (MDC/MDIO write/read serializer) between NUM_REQ requesters, e.g. the PHY init sequencer, a link-status poller and a host register port. Uses round-robin arbitration, one transaction in flight at a time. Latches the winner's command, launches the engine, and waits for completion or timeout. Returns a per-requester done pulse, read data and an error flag.

---
 rtl/mdio_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO frame engine among NUM_REQ requesters.
// One transaction in flight: latch winner's command, launch, await done edge or timeout.
module mdio_arbiter #(
    parameter int              NUM_REQ     = 3,
    parameter int              TO_W        = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 24'd100000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ-1:0]    i_req_wr,
    input  logic [5*NUM_REQ-1:0]  i_req_phy_ad,
    input  logic [5*NUM_REQ-1:0]  i_req_reg_ad,
    input  logic [16*NUM_REQ-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]    o_gnt,
    output logic [NUM_REQ-1:0]    o_done,
    output logic                  o_err,
    output logic [15:0]           o_rdata,
    output logic                  o_eng_start,
    output logic                  o_eng_wr,
    output logic [4:0]            o_eng_phy_ad,
    output logic [4:0]            o_eng_reg_ad,
    output logic [15:0]           o_eng_wdata,
    input  logic                  i_eng_busy,
    input  logic                  i_eng_done,
    input  logic [15:0]           i_eng_rdata
);

    localparam int              IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TO_W-1:0] TO_LAST  = TIMEOUT_CYC - 1'b1;
    localparam logic [IW-1:0]   LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       last_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                err_q;
    logic                wr_q;
    logic [4:0]          phy_q;
    logic [4:0]          reg_q;
    logic [15:0]         wdata_q;
    logic [15:0]         rdata_q;
    logic [TO_W-1:0]     cnt_q;
    logic                done_dly_q;

    logic                done_edge;
    logic [IW-1:0]       win_idx;
    logic [4:0]          phy_arr   [NUM_REQ];
    logic [4:0]          reg_arr   [NUM_REQ];
    logic [15:0]         wdata_arr [NUM_REQ];
    logic [IW-1:0]       cand      [NUM_REQ];

    assign done_edge = i_eng_done & ~done_dly_q;

    // cand[k] = (last + k + 1) mod NUM_REQ, the k-th candidate in the scan order
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [IW:0] sum;
            assign phy_arr[gi]   = i_req_phy_ad[5*gi +: 5];
            assign reg_arr[gi]   = i_req_reg_ad[5*gi +: 5];
            assign wdata_arr[gi] = i_req_wdata[16*gi +: 16];
            assign sum           = {1'b0, last_q} + (IW+1)'(gi + 1);
            assign cand[gi]      = (sum >= (IW+1)'(NUM_REQ)) ?
                                   IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
        end
    endgenerate

    always_comb begin
        win_idx = cand[NUM_REQ-1];
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[cand[k]]) begin
                win_idx = cand[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            last_q     <= LAST_RST;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            wr_q       <= 1'b0;
            phy_q      <= 5'h1F;
            reg_q      <= 5'h1F;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            done_dly_q <= 1'b0;
        end else begin
            done_dly_q <= i_eng_done;
            done_q     <= '0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|i_req) begin
                        idx_q   <= win_idx;
                        gnt_q   <= NUM_REQ'(1) << win_idx;
                        wr_q    <= i_req_wr[win_idx];
                        phy_q   <= phy_arr[win_idx];
                        reg_q   <= reg_arr[win_idx];
                        wdata_q <= wdata_arr[win_idx];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!i_eng_busy) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A done edge in the timeout cycle still counts as success
                    if (done_edge) begin
                        if (!wr_q) begin
                            rdata_q <= i_eng_rdata;
                        end
                        done_q  <= gnt_q;
                        state_q <= DONE;
                    end else if (cnt_q == TO_LAST) begin
                        done_q  <= gnt_q;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    last_q  <= idx_q;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_eng_start  = (state_q == ISSUE) & ~i_eng_busy;
    assign o_gnt        = gnt_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_rdata      = rdata_q;
    assign o_eng_wr     = wr_q;
    assign o_eng_phy_ad = phy_q;
    assign o_eng_reg_ad = reg_q;
    assign o_eng_wdata  = wdata_q;

endmodule
